// File: rtl/reg_wb_pkg.sv
// Shared types for the register file write-back arbiter: widths, queue entry and port index.
// Used by wb_fifo and reg_wb_arbiter; REG0_DROP_EN is handled in reg_wb_arbiter.
package reg_wb_pkg;

    localparam int AW   = 4;
    localparam int DW   = 16;
    localparam int NREG = 2 ** AW;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_entry_t;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_t;

    function automatic logic [NREG-1:0] addr_onehot(input logic [AW-1:0] a);
        addr_onehot    = '0;
        addr_onehot[a] = 1'b1;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-port write-back queue: in-order FIFO of DEPTH entries with per-slot valid bits
// and a flattened view of the queued destination addresses for the pending map.
module wb_fifo
    import reg_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  wb_entry_t           push_entry,
    input  logic                pop,
    output logic                full,
    output logic                empty,
    output wb_entry_t           head,
    output logic [DEPTH*AW-1:0] flat_addr,
    output logic [DEPTH-1:0]    slot_valid
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_entry_t        mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [DEPTH-1:0] vld;
    logic             do_push;
    logic             do_pop;

    assign full    = &vld;
    assign empty   = ~|vld;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rptr];
    assign slot_valid = vld;

    // Push and pop never target the same slot: that would need the queue to be both full and empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            vld  <= '0;
        end else begin
            if (do_push) begin
                vld[wptr] <= 1'b1;
                wptr      <= wptr + 1'b1;
            end
            if (do_pop) begin
                vld[rptr] <= 1'b0;
                rptr      <= rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= push_entry;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_flat
        assign flat_addr[i*AW +: AW] = mem[i].addr;
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Round-robin write-back arbiter feeding the register file write port, with pending map.
// Optional REG0_DROP_EN: writes to register 0 are suppressed at the output and never marked pending.
module reg_wb_arbiter #(
    parameter int DEPTH = 2,
    parameter int AW    = reg_wb_pkg::AW,
    parameter int DW    = reg_wb_pkg::DW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [AW-1:0]     req0_addr,
    input  logic [DW-1:0]     req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [AW-1:0]     req1_addr,
    input  logic [DW-1:0]     req1_data,
    output logic              wen,
    output logic [AW-1:0]     rwr,
    output logic [DW-1:0]     dwr,
    output logic [2**AW-1:0]  pending,
    output logic              idle
);

    typedef reg_wb_pkg::wb_entry_t entry_t;
    typedef reg_wb_pkg::port_t     port_t;

    entry_t              in0;
    entry_t              in1;
    entry_t              head0;
    entry_t              head1;
    entry_t              sel;
    logic                full0;
    logic                full1;
    logic                empty0;
    logic                empty1;
    logic                gnt0;
    logic                gnt1;
    logic [DEPTH*AW-1:0] addrs0;
    logic [DEPTH*AW-1:0] addrs1;
    logic [DEPTH-1:0]    sv0;
    logic [DEPTH-1:0]    sv1;
    port_t               last_grant;
    logic                write_ok;

    assign in0        = '{addr: req0_addr, data: req0_data};
    assign in1        = '{addr: req1_addr, data: req1_data};
    assign req0_ready = !full0;
    assign req1_ready = !full1;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo0 (
        .clk        (clk),
        .rst        (rst),
        .push       (req0_valid),
        .push_entry (in0),
        .pop        (gnt0),
        .full       (full0),
        .empty      (empty0),
        .head       (head0),
        .flat_addr  (addrs0),
        .slot_valid (sv0)
    );

    wb_fifo #(.DEPTH(DEPTH)) u_fifo1 (
        .clk        (clk),
        .rst        (rst),
        .push       (req1_valid),
        .push_entry (in1),
        .pop        (gnt1),
        .full       (full1),
        .empty      (empty1),
        .head       (head1),
        .flat_addr  (addrs1),
        .slot_valid (sv1)
    );

    // Under contention the port that did not win last time is served.
    assign gnt0 = !empty0 && (empty1 || last_grant == reg_wb_pkg::PORT1);
    assign gnt1 = !empty1 && (empty0 || last_grant == reg_wb_pkg::PORT0);
    assign sel  = gnt1 ? head1 : head0;

`ifdef REG0_DROP_EN
    assign write_ok = (sel.addr != '0);
`else
    assign write_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= reg_wb_pkg::PORT1;
            wen        <= 1'b0;
            rwr        <= '0;
            dwr        <= '0;
        end else if (gnt0 || gnt1) begin
            last_grant <= gnt1 ? reg_wb_pkg::PORT1 : reg_wb_pkg::PORT0;
            wen        <= write_ok;
            rwr        <= sel.addr;
            dwr        <= sel.data;
        end else begin
            wen <= 1'b0;
        end
    end

    // A write stays pending until the cycle the register file commits it has ended.
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sv0[i]) begin
                pending = pending | reg_wb_pkg::addr_onehot(addrs0[i*AW +: AW]);
            end
            if (sv1[i]) begin
                pending = pending | reg_wb_pkg::addr_onehot(addrs1[i*AW +: AW]);
            end
        end
        if (wen) begin
            pending = pending | reg_wb_pkg::addr_onehot(rwr);
        end
`ifdef REG0_DROP_EN
        pending[0] = 1'b0;
`endif
    end

    assign idle = empty0 && empty1 && !wen;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: queue-based reference model plus per-scenario checks.
// Expectations for register 0 follow REG0_DROP_EN when it is defined for the build.
module tb_reg_wb_arbiter;

    localparam int DEPTH = 2;
`ifdef REG0_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]  a;
        logic [15:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid;
    logic        req0_ready;
    logic [3:0]  req0_addr;
    logic [15:0] req0_data;
    logic        req1_valid;
    logic        req1_ready;
    logic [3:0]  req1_addr;
    logic [15:0] req1_data;
    logic        wen;
    logic [3:0]  rwr;
    logic [15:0] dwr;
    logic [15:0] pending;
    logic        idle;

    int checks = 0;
    int errors = 0;

    ent_t sb0[$];
    ent_t sb1[$];
    bit   m_last  = 1'b1;
    bit   m_out_v = 1'b0;
    ent_t m_out   = '0;
    int   n_acc0  = 0;
    int   n_acc1  = 0;

    always #5 clk = ~clk;

    reg_wb_arbiter #(.DEPTH(DEPTH), .AW(4), .DW(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .wen        (wen),
        .rwr        (rwr),
        .dwr        (dwr),
        .pending    (pending),
        .idle       (idle)
    );

    // Reference model: accepted writes queue per port; a grant moves the head into the output slot.
    always @(posedge clk) begin : model
        bit take0, take1, g0, g1;
        if (rst) begin
            sb0.delete();
            sb1.delete();
            m_last  = 1'b1;
            m_out_v = 1'b0;
            m_out   = '0;
        end else begin
            take0   = req0_valid && (sb0.size() < DEPTH);
            take1   = req1_valid && (sb1.size() < DEPTH);
            g0      = (sb0.size() != 0) && ((sb1.size() == 0) || m_last);
            g1      = (sb1.size() != 0) && ((sb0.size() == 0) || !m_last);
            m_out_v = g0 || g1;
            if (g0) begin
                m_out  = sb0.pop_front();
                m_last = 1'b0;
            end else if (g1) begin
                m_out  = sb1.pop_front();
                m_last = 1'b1;
            end
            if (take0) begin
                sb0.push_back({req0_addr, req0_data});
                n_acc0++;
            end
            if (take1) begin
                sb1.push_back({req1_addr, req1_data});
                n_acc1++;
            end
        end
    end

    function automatic bit exp_wen();
        return m_out_v && !(DROP && m_out.a == 4'd0);
    endfunction

    function automatic logic [15:0] exp_pending();
        logic [15:0] p;
        p = '0;
        foreach (sb0[i]) p[sb0[i].a] = 1'b1;
        foreach (sb1[i]) p[sb1[i].a] = 1'b1;
        if (exp_wen()) p[m_out.a] = 1'b1;
        if (DROP) p[0] = 1'b0;
        return p;
    endfunction

    function automatic bit exp_ready0();
        return sb0.size() < DEPTH;
    endfunction

    function automatic bit exp_ready1();
        return sb1.size() < DEPTH;
    endfunction

    function automatic bit exp_idle();
        return (sb0.size() == 0) && (sb1.size() == 0) && !exp_wen();
    endfunction

    task automatic drive(input bit r, input bit v0, input logic [3:0] a0, input logic [15:0] d0,
                         input bit v1, input logic [3:0] a1, input logic [15:0] d1);
        rst        = r;
        req0_valid = v0;
        req0_addr  = a0;
        req0_data  = d0;
        req1_valid = v1;
        req1_addr  = a1;
        req1_data  = d1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({wen, rwr, dwr} !== {1'b0, 4'd0, 16'd0}) begin
            errors++;
            $display("[TB] FAIL reset.out: got wen=%0b rwr=%0d dwr=%h, want 0 0 0000", wen, rwr, dwr);
        end
        checks++;
        if (pending !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset.pending: got %h want 0000", pending);
        end
        checks++;
        if ({req0_ready, req1_ready, idle} !== 3'b111) begin
            errors++;
            $display("[TB] FAIL reset.status: got ready0=%0b ready1=%0b idle=%0b, want 1 1 1",
                     req0_ready, req1_ready, idle);
        end
    endtask

    task automatic test_single();
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, c == 0, 4'd5, 16'h1234, 1'b0, 4'd0, 16'd0);
            @(negedge clk);
            checks++;
            if ({wen, rwr, dwr} !== {exp_wen(), m_out.a, m_out.d}) begin
                errors++;
                $display("[TB] FAIL single.out c%0d: got wen=%0b rwr=%0d dwr=%h, want wen=%0b rwr=%0d dwr=%h",
                         c, wen, rwr, dwr, exp_wen(), m_out.a, m_out.d);
            end
            checks++;
            if (pending !== exp_pending()) begin
                errors++;
                $display("[TB] FAIL single.pending c%0d: got %h want %h", c, pending, exp_pending());
            end
            checks++;
            if ({req0_ready, req1_ready, idle} !== {exp_ready0(), exp_ready1(), exp_idle()}) begin
                errors++;
                $display("[TB] FAIL single.status c%0d: got %b want %b", c,
                         {req0_ready, req1_ready, idle}, {exp_ready0(), exp_ready1(), exp_idle()});
            end
            if (c == 1) begin
                checks++;
                if ({wen, rwr, dwr, pending[5]} !== {1'b1, 4'd5, 16'h1234, 1'b1}) begin
                    errors++;
                    $display("[TB] FAIL single.slot: got wen=%0b rwr=%0d dwr=%h pend5=%0b, want 1 5 1234 1",
                             wen, rwr, dwr, pending[5]);
                end
            end
            if (c == 2) begin
                checks++;
                if ({wen, idle, pending[5]} !== 3'b010) begin
                    errors++;
                    $display("[TB] FAIL single.done: got wen=%0b idle=%0b pend5=%0b, want 0 1 0",
                             wen, idle, pending[5]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] obs [4];
        logic [3:0] want [4];
        int n_obs;
        int base0;
        int base1;
        bit saw_full0;
        bit saw_full1;
        want = '{4'd1, 4'd9, 4'd2, 4'd10};
        obs  = '{4'd0, 4'd0, 4'd0, 4'd0};
        n_obs = 0;
        saw_full0 = 1'b0;
        saw_full1 = 1'b0;
        base0 = 0;
        base1 = 0;
        for (int c = 0; c < 28; c++) begin
            if (c == 1) begin
                base0 = n_acc0;
                base1 = n_acc1;
            end
            drive(c == 0,
                  c >= 1 && c <= 20, 4'(1 + (n_acc0 - base0) % 7), 16'(16'h1000 + n_acc0 - base0),
                  c >= 1 && c <= 20, 4'(9 + (n_acc1 - base1) % 7), 16'(16'h2000 + n_acc1 - base1));
            @(negedge clk);
            checks++;
            if ({wen, rwr, dwr} !== {exp_wen(), m_out.a, m_out.d}) begin
                errors++;
                $display("[TB] FAIL b2b.out c%0d: got wen=%0b rwr=%0d dwr=%h, want wen=%0b rwr=%0d dwr=%h",
                         c, wen, rwr, dwr, exp_wen(), m_out.a, m_out.d);
            end
            checks++;
            if (pending !== exp_pending()) begin
                errors++;
                $display("[TB] FAIL b2b.pending c%0d: got %h want %h", c, pending, exp_pending());
            end
            checks++;
            if ({req0_ready, req1_ready, idle} !== {exp_ready0(), exp_ready1(), exp_idle()}) begin
                errors++;
                $display("[TB] FAIL b2b.status c%0d: got %b want %b", c,
                         {req0_ready, req1_ready, idle}, {exp_ready0(), exp_ready1(), exp_idle()});
            end
            if (wen === 1'b1 && n_obs < 4) begin
                obs[n_obs] = rwr;
                n_obs++;
            end
            if (req0_ready === 1'b0) saw_full0 = 1'b1;
            if (req1_ready === 1'b0) saw_full1 = 1'b1;
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs[i] !== want[i]) begin
                errors++;
                $display("[TB] FAIL b2b.order[%0d]: got rwr=%0d want %0d", i, obs[i], want[i]);
            end
        end
        checks++;
        if ({saw_full0, saw_full1} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL b2b.backpressure: got full0_seen=%0b full1_seen=%0b, want 1 1",
                     saw_full0, saw_full1);
        end
    endtask

    task automatic test_full();
        int base0;
        int base1;
        int outs1;
        bit saw_full1;
        base0 = n_acc0;
        base1 = n_acc1;
        outs1 = 0;
        saw_full1 = 1'b0;
        for (int c = 0; c < 16; c++) begin
            drive(1'b0,
                  (n_acc0 - base0) < 3, 4'(1 + n_acc0 - base0), 16'(16'h3000 + n_acc0 - base0),
                  (n_acc1 - base1) < 4, 4'(12 + n_acc1 - base1), 16'(16'h4000 + n_acc1 - base1));
            @(negedge clk);
            checks++;
            if ({wen, rwr, dwr} !== {exp_wen(), m_out.a, m_out.d}) begin
                errors++;
                $display("[TB] FAIL full.out c%0d: got wen=%0b rwr=%0d dwr=%h, want wen=%0b rwr=%0d dwr=%h",
                         c, wen, rwr, dwr, exp_wen(), m_out.a, m_out.d);
            end
            checks++;
            if (pending !== exp_pending()) begin
                errors++;
                $display("[TB] FAIL full.pending c%0d: got %h want %h", c, pending, exp_pending());
            end
            checks++;
            if ({req0_ready, req1_ready, idle} !== {exp_ready0(), exp_ready1(), exp_idle()}) begin
                errors++;
                $display("[TB] FAIL full.status c%0d: got %b want %b", c,
                         {req0_ready, req1_ready, idle}, {exp_ready0(), exp_ready1(), exp_idle()});
            end
            if (wen === 1'b1 && rwr >= 4'd12) outs1++;
            if (req1_ready === 1'b0) saw_full1 = 1'b1;
        end
        checks++;
        if (outs1 != 4 || saw_full1 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full.port1: got writes=%0d full_seen=%0b, want 4 1", outs1, saw_full1);
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 7; c++) begin
            drive(c == 2,
                  c == 0 || c == 1 || c == 3,
                  (c == 3) ? 4'd7 : 4'(2 + c),
                  (c == 3) ? 16'hBEEF : 16'(16'h5000 + c),
                  c == 0, 4'd10, 16'h6000);
            @(negedge clk);
            checks++;
            if ({wen, rwr, dwr} !== {exp_wen(), m_out.a, m_out.d}) begin
                errors++;
                $display("[TB] FAIL rstmid.out c%0d: got wen=%0b rwr=%0d dwr=%h, want wen=%0b rwr=%0d dwr=%h",
                         c, wen, rwr, dwr, exp_wen(), m_out.a, m_out.d);
            end
            checks++;
            if (pending !== exp_pending()) begin
                errors++;
                $display("[TB] FAIL rstmid.pending c%0d: got %h want %h", c, pending, exp_pending());
            end
            checks++;
            if ({req0_ready, req1_ready, idle} !== {exp_ready0(), exp_ready1(), exp_idle()}) begin
                errors++;
                $display("[TB] FAIL rstmid.status c%0d: got %b want %b", c,
                         {req0_ready, req1_ready, idle}, {exp_ready0(), exp_ready1(), exp_idle()});
            end
            if (c == 2) begin
                checks++;
                if ({wen, pending, req0_ready, req1_ready, idle} !== {1'b0, 16'h0000, 3'b111}) begin
                    errors++;
                    $display("[TB] FAIL rstmid.cleared: got wen=%0b pend=%h rdy=%0b%0b idle=%0b, want 0 0000 11 1",
                             wen, pending, req0_ready, req1_ready, idle);
                end
            end
            if (c == 3) begin
                checks++;
                if ({wen, pending} !== {1'b0, 16'h0080}) begin
                    errors++;
                    $display("[TB] FAIL rstmid.queued: got wen=%0b pend=%h, want 0 0080", wen, pending);
                end
            end
            if (c == 4) begin
                checks++;
                if ({wen, rwr, dwr} !== {1'b1, 4'd7, 16'hBEEF}) begin
                    errors++;
                    $display("[TB] FAIL rstmid.next: got wen=%0b rwr=%0d dwr=%h, want 1 7 beef", wen, rwr, dwr);
                end
            end
        end
    endtask

    task automatic test_reg0();
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, c == 0, 4'd0, 16'hFFFF, 1'b0, 4'd0, 16'd0);
            @(negedge clk);
            checks++;
            if ({wen, rwr, dwr} !== {exp_wen(), m_out.a, m_out.d}) begin
                errors++;
                $display("[TB] FAIL reg0.out c%0d: got wen=%0b rwr=%0d dwr=%h, want wen=%0b rwr=%0d dwr=%h",
                         c, wen, rwr, dwr, exp_wen(), m_out.a, m_out.d);
            end
            checks++;
            if (pending !== exp_pending()) begin
                errors++;
                $display("[TB] FAIL reg0.pending c%0d: got %h want %h", c, pending, exp_pending());
            end
            if (c == 0) begin
                checks++;
                if (pending[0] !== ~DROP) begin
                    errors++;
                    $display("[TB] FAIL reg0.queued: got pend0=%0b want %0b", pending[0], ~DROP);
                end
            end
            if (c == 1) begin
                checks++;
                if ({wen, rwr, dwr, pending[0]} !== {~DROP, 4'd0, 16'hFFFF, ~DROP}) begin
                    errors++;
                    $display("[TB] FAIL reg0.slot: got wen=%0b rwr=%0d dwr=%h pend0=%0b, want %0b 0 ffff %0b",
                             wen, rwr, dwr, pending[0], ~DROP, ~DROP);
                end
            end
        end
    endtask

    task automatic test_same_addr();
        for (int c = 0; c < 6; c++) begin
            drive(c == 0, c == 1, 4'd4, 16'hAAAA, c == 1, 4'd4, 16'h5555);
            @(negedge clk);
            checks++;
            if ({wen, rwr, dwr} !== {exp_wen(), m_out.a, m_out.d}) begin
                errors++;
                $display("[TB] FAIL waw.out c%0d: got wen=%0b rwr=%0d dwr=%h, want wen=%0b rwr=%0d dwr=%h",
                         c, wen, rwr, dwr, exp_wen(), m_out.a, m_out.d);
            end
            checks++;
            if (pending !== exp_pending()) begin
                errors++;
                $display("[TB] FAIL waw.pending c%0d: got %h want %h", c, pending, exp_pending());
            end
            if (c == 2) begin
                checks++;
                if ({wen, rwr, dwr, pending[4]} !== {1'b1, 4'd4, 16'hAAAA, 1'b1}) begin
                    errors++;
                    $display("[TB] FAIL waw.first: got wen=%0b rwr=%0d dwr=%h pend4=%0b, want 1 4 aaaa 1",
                             wen, rwr, dwr, pending[4]);
                end
            end
            if (c == 3) begin
                checks++;
                if ({wen, rwr, dwr, pending[4]} !== {1'b1, 4'd4, 16'h5555, 1'b1}) begin
                    errors++;
                    $display("[TB] FAIL waw.second: got wen=%0b rwr=%0d dwr=%h pend4=%0b, want 1 4 5555 1",
                             wen, rwr, dwr, pending[4]);
                end
            end
            if (c == 4) begin
                checks++;
                if ({wen, pending[4], idle} !== 3'b001) begin
                    errors++;
                    $display("[TB] FAIL waw.done: got wen=%0b pend4=%0b idle=%0b, want 0 0 1",
                             wen, pending[4], idle);
                end
            end
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
        $display("[TB] reg_wb_arbiter bench start, DEPTH=%0d DROP=%0b", DEPTH, DROP);
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_reset_mid();
        test_reg0();
        test_same_addr();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_wb_arbiter.md
# reg_wb_arbiter

Write-back arbiter and queue for the 16 x 16-bit register file's single write port. Two independent write-back sources (port 0: ALU result path, port 1: memory load path) each push writes through a valid/ready handshake into a private FIFO. A round-robin arbiter drains the FIFOs onto the register file's `wen`/`rwr`/`dwr` port at most once per cycle. A per-register pending map lets the multicycle control FSM stall reads of registers with writes still in flight.

## Interface
- `DEPTH`, 2: entries per requester FIFO; a power of two, at least 2.
- `AW`, 4: register address width.
- `DW`, 16: register data width.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req0_valid`  in  1: port 0 write request.
- `req0_ready`  out  1: port 0 FIFO can accept an entry.
- `req0_addr`  in  AW: port 0 destination register.
- `req0_data`  in  DW: port 0 write data.
- `req1_valid`, `req1_ready`, `req1_addr`, `req1_data`: port 1; same widths and meaning as port 0.
- `wen`  out  1: register file write enable, registered.
- `rwr`  out  AW: register file write address, registered.
- `dwr`  out  DW: register file write data, registered.
- `pending`  out  2**AW: bit a is set while any queued or outputting write targets register a.
- `idle`  out  1: both FIFOs are empty and `wen` is 0.

## Operation
- **Accept:** a push happens on a rising edge where `reqN_valid & reqN_ready` is high. `reqN_ready = !fullN`, computed from the registered FIFO state only. It does not depend on `valid` or on a same-cycle pop.
- **FIFO:** in-order within each port. A push and a pop in the same cycle on a non-full, non-empty FIFO are both performed. The pop sees only entries present at the start of the cycle, so there is no pass-through from input to `wen`.
- **Arbitration:** one grant per cycle among non-empty FIFOs.
  - If only one FIFO is non-empty, it is granted.
  - If both are non-empty, the port not granted last is granted.
  - The `last_grant` pointer updates only on a grant.
- **Output stage:** on a grant, the popped entry loads `rwr`/`dwr` and `wen` goes to 1. With no grant, `wen` goes to 0 and `rwr`/`dwr` hold their values.
- **Ordering:** writes from one port reach the register file in push order. Ordering between ports follows grant order only. Cross-port write-after-write to the same register is resolved by the control FSM using `pending`.
- **Pending:** a combinational OR over all valid FIFO entries of both ports plus the output stage (when `wen` = 1). A write therefore keeps its `pending` bit through the cycle the register file commits it.
- **Reset (`rst` = 1 at an edge), including mid-operation:**
  - Both FIFOs are emptied.
  - `last_grant` = 1, so port 0 wins first.
  - `wen` = 0, `rwr` = 0, `dwr` = 0.
  - Queued writes are discarded and never reach the register file.
  - After that edge: `pending` = 0, `idle` = 1, both `ready` = 1.

## Timing
- Latency: a push accepted at edge k into an empty FIFO with no competing grant is popped at edge k+1. `wen` is high from edge k+1 to edge k+2. The register file commits it on the falling edge inside that window.
- Throughput: one register file write per cycle in aggregate. With both ports saturated, each port gets one write every 2 cycles.
- Full: with `DEPTH` entries, `ready` drops the cycle after the filling push. It rises the cycle after the first pop.
- Empty: `idle` rises the cycle after the final output cycle.

## Configuration
- `REG0_DROP_EN`
  - **Defined:** writes to address 0 are accepted, queued and arbitrated normally, but the output cycle they occupy drives `wen` = 0 (`rwr`/`dwr` still load). `pending[0]` is tied to 0. This keeps `$zero` constant.
  - **Not defined:** address 0 is written like any other register and `pending[0]` follows the normal rule.

## Structure
- **Package `reg_wb_pkg`:**
  - `AW`, `DW` and `NREG` = 2**AW.
  - A typedef `wb_entry_t` = {addr[AW-1:0], data[DW-1:0]}.
  - A 1-bit port-index type for `last_grant`.
- **Sub-module `wb_fifo`:** parameterised by `DEPTH`, instantiated once per port. It exposes full, empty, head entry and a flattened view of all entries with per-slot valid bits for the pending OR.
- **Top level:** the arbiter, output register and pending logic live in the top level.

## Test plan
- Reset, then a single push on port 0 (addr 5, data 0x1234) at edge 1 -> `wen` = 1, `rwr` = 5, `dwr` = 0x1234 between edges 2 and 3. `pending[5]` is 1 from edge 1 through edge 3. `idle` = 1 after edge 3.
- Both ports push every cycle (port 0: addr 1, 2, 3...; port 1: addr 9, 10, 11...) -> the output alternates 1, 9, 2, 10, ... starting with port 0. Each `ready` deasserts once its FIFO fills. Every write appears exactly once, in order per port.
- Fill port 1 to `DEPTH` = 2 with `valid` held high -> `req1_ready` = 0 the cycle after the second push. The third entry is accepted only after the first pop. No entry is lost or duplicated.
- Queue 3 writes, then assert `rst` for one edge -> `wen` stays 0 afterwards, `pending` = 0, both `ready` = 1. The next push (addr 7, data 0xBEEF) appears 2 cycles later.
- Push addr 0, data 0xFFFF on port 0 -> with `REG0_DROP_EN` defined: `wen` = 0 in its slot and `pending[0]` = 0. Without it: `wen` = 1, `rwr` = 0, `dwr` = 0xFFFF.
- Port 0 pushes addr 4 / 0xAAAA and port 1 pushes addr 4 / 0x5555 on the same edge -> port 0 is written first, then port 1. `pending[4]` stays 1 until the second write's output cycle ends.
